instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Writer-side counterpart to the instruction memory read port.
- Accepts a byte stream over a valid/ready handshake.
- Packs bytes little-endian into 32-bit words.
- Issues one-cycle word writes to sequential word-aligned addresses in instruction memory, starting at a base address.
- Used to preload program images before the PC is released from reset.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; must be word-aligned.
- MEM_WORDS, 1024: instruction memory capacity in words (4 KiB); bounds the image size.
- CNT_W, 11: width of the word counter; must be at least clog2(MEM_WORDS+1).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load session.
- i_byte_valid  input  1  producer has a byte on i_byte.
- i_byte  input  8  image byte.
- i_last  input  1  qualifies the accepted byte as the final byte of the image.
- o_byte_ready  output  1  loader can accept a byte this cycle.
- o_we  output  1  instruction memory write enable.
- o_waddr  output  32  write byte address; bits [1:0] always 0.
- o_wdata  output  32  write data word.
- o_busy  output  1  session in progress (state COLLECT or WRITE).
- o_done  output  1  image fully written; sticky.
- o_overflow  output  1  image exceeded MEM_WORDS; sticky.
- o_word_count  output  CNT_W  words written in the current or last session.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - All outputs 0: o_waddr=0, o_wdata=0, o_word_count=0.
  - Partial word and byte index cleared.
  - Reset mid-session discards the partial word; no write is issued.
- A byte transfer occurs on a cycle with i_byte_valid=1 and o_byte_ready=1. Otherwise i_byte and i_last are ignored. The producer holds its data until accepted.
- Packing:
  - Byte index k (0..3) goes to bits [8k+7:8k].
  - Unfilled bytes of a partial final word are 0.
- States:
  - IDLE:
    - o_byte_ready=0.
    - start → COLLECT; clears byte index, word count, partial word, o_done and o_overflow.
  - COLLECT:
    - o_byte_ready=1.
    - The accepted byte completing index 3 → WRITE.
    - An accepted byte with i_last=1 → WRITE at any index, with the last flag latched.
    - start is ignored.
  - WRITE (exactly one cycle):
    - o_byte_ready=0.
    - If word count < MEM_WORDS:
      - o_we=1, o_waddr=BASE_ADDR+4*count, o_wdata=packed word.
      - Next cycle: count+1, byte index 0, partial word cleared.
      - Next state: DONE if the last flag is set, else COLLECT.
    - If word count = MEM_WORDS: o_we=0, next state ERROR.
  - DONE:
    - o_done=1, o_byte_ready=0.
    - start → COLLECT (new session, clears as in IDLE).
  - ERROR:
    - o_overflow=1, o_byte_ready=0.
    - start → COLLECT (clears as in IDLE); otherwise held until rst.
- Timing and outputs:
  - Latency: a completing byte accepted at edge n produces o_we=1 during cycle n+1. o_byte_ready returns high in cycle n+2.
  - Peak throughput: 4 bytes per 5 cycles.
  - o_we is asserted only in WRITE; never two consecutive cycles.
  - o_waddr and o_wdata hold their last written values when o_we=0.
  - o_word_count updates the cycle after each write and holds after DONE or ERROR.
  - o_busy=1 exactly in COLLECT and WRITE.
- Simultaneous events:
  - rst has priority over start and the handshake.
  - start together with i_byte_valid in IDLE: the byte is not accepted (ready=0 that cycle).
- Address arithmetic is 32-bit; count×4 cannot exceed BASE_ADDR+4*(MEM_WORDS-1) because of the overflow check.

Test Plan:
- Full words: start, stream 8 bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 with i_last on byte 8.
  - Writes (0x0, 0x00000013) and (0x4, 0x00100093).
  - o_done=1, o_word_count=2.
- Partial final word: stream 0xAA,0xBB with i_last on byte 2.
  - Single write (0x0, 0x0000BBAA).
  - o_done=1, o_word_count=1.
- Backpressure timing: valid held high continuously across 4 bytes.
  - o_we high exactly one cycle after byte 4.
  - o_byte_ready low during that cycle and high the next.
  - Bytes during low ready are not consumed.
- Overflow: MEM_WORDS=2, stream 12 bytes, i_last on byte 12.
  - Two writes at 0x0 and 0x4, no third write.
  - o_overflow=1, o_done=0, o_word_count=2.
- Reset mid-word: accept 2 bytes, assert rst for one cycle.
  - No o_we, all outputs 0, state IDLE.
  - A subsequent start then 4 bytes writes at BASE_ADDR.
- Restart and ignored start: start pulse during COLLECT has no effect. start in DONE begins a new session with o_done cleared, o_word_count=0, first write at BASE_ADDR.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader
//   Streams a program image into instruction memory before the core is
//   released from reset. Bytes arrive over a valid/ready handshake, are
//   packed little-endian into 32-bit words and written one word per write
//   cycle to consecutive word addresses starting at BASE_ADDR.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   start          one-cycle pulse that opens a load session
//   i_byte_valid   producer presents i_byte / i_last
//   i_byte         image byte
//   i_last         accepted byte is the final byte of the image
//   o_byte_ready   loader accepts a byte this cycle
//   o_we           instruction memory write enable (single cycle)
//   o_waddr        word-aligned write byte address (holds last write)
//   o_wdata        write data word (holds last write)
//   o_busy         session in progress
//   o_done         image fully written (sticky until next start)
//   o_overflow     image larger than MEM_WORDS (sticky until next start)
//   o_word_count   words written in the current or last session
//
// State table
//   state     | meaning
//   S_IDLE    | after reset, waiting for start
//   S_COLLECT | accepting bytes into the partial word
//   S_WRITE   | one cycle: write the packed word, or detect overflow
//   S_DONE    | last word written; waiting for a new start
//   S_ERROR   | image did not fit; waiting for a new start or rst
module instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte,
  input  logic             i_last,
  output logic             o_byte_ready,
  output logic             o_we,
  output logic [31:0]      o_waddr,
  output logic [31:0]      o_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_word_count
);

  localparam logic [CNT_W-1:0] MEM_WORDS_C = CNT_W'(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       byte_idx_q;
  logic [31:0]      word_q;
  logic             last_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      waddr_q;
  logic [31:0]      wdata_q;

  logic             accept;
  logic             room;
  logic             session_start;
  logic             write_fire;
  logic [31:0]      count_bytes;
  logic [31:0]      wr_addr;

  assign accept      = (state_q == S_COLLECT) && i_byte_valid;
  assign room        = (count_q < MEM_WORDS_C);
  assign count_bytes = 32'(count_q) << 2;
  assign wr_addr     = BASE_ADDR + count_bytes;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control outputs
  always_comb begin
    state_d       = state_q;
    session_start = 1'b0;
    write_fire    = 1'b0;
    o_byte_ready  = 1'b0;
    o_we          = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_overflow    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          session_start = 1'b1;
          state_d       = S_COLLECT;
        end
      end

      S_COLLECT: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
        // A word is closed either by its fourth byte or by the image end.
        if (i_byte_valid && ((byte_idx_q == 2'd3) || i_last)) begin
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        o_busy = 1'b1;
        if (room) begin
          o_we       = 1'b1;
          write_fire = 1'b1;
          state_d    = last_q ? S_DONE : S_COLLECT;
        end else begin
          state_d = S_ERROR;
        end
      end

      S_DONE: begin
        o_done = 1'b1;
        if (start) begin
          session_start = 1'b1;
          state_d       = S_COLLECT;
        end
      end

      S_ERROR: begin
        o_overflow = 1'b1;
        if (start) begin
          session_start = 1'b1;
          state_d       = S_COLLECT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Packing, word counter and write-port hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      last_q     <= 1'b0;
      count_q    <= '0;
      waddr_q    <= 32'd0;
      wdata_q    <= 32'd0;
    end else if (session_start) begin
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      last_q     <= 1'b0;
      count_q    <= '0;
    end else if (accept) begin
      word_q[{byte_idx_q, 3'b000} +: 8] <= i_byte;
      byte_idx_q <= byte_idx_q + 2'd1;
      last_q     <= i_last;
    end else if (write_fire) begin
      count_q    <= count_q + 1'b1;
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      waddr_q    <= wr_addr;
      wdata_q    <= word_q;
    end
  end

  // The live address/data are shown during the write cycle itself; the
  // registered copies keep the port stable between writes.
  assign o_waddr      = o_we ? wr_addr : waddr_q;
  assign o_wdata      = o_we ? word_q  : wdata_q;
  assign o_word_count = count_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        bvalid;
  logic [7:0]  bval;
  logic        blast;

  logic        rdy0, we0, busy0, done0, ovf0;
  logic [31:0] waddr0, wdata0;
  logic [10:0] cnt0;
  logic        rdy1, we1, busy1, done1, ovf1;
  logic [31:0] waddr1, wdata1;
  logic [1:0]  cnt1;

  int checks;
  int failures;

  instr_loader dut0 (
    .clk(clk), .rst(rst), .start(start), .i_byte_valid(bvalid), .i_byte(bval),
    .i_last(blast), .o_byte_ready(rdy0), .o_we(we0), .o_waddr(waddr0),
    .o_wdata(wdata0), .o_busy(busy0), .o_done(done0), .o_overflow(ovf0),
    .o_word_count(cnt0)
  );

  instr_loader #(.BASE_ADDR(32'h0), .MEM_WORDS(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .i_byte_valid(bvalid), .i_byte(bval),
    .i_last(blast), .o_byte_ready(rdy1), .o_we(we1), .o_waddr(waddr1),
    .o_wdata(wdata1), .o_busy(busy1), .o_done(done1), .o_overflow(ovf1),
    .o_word_count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Write monitors: capture every write and check per-write invariants.
  logic [63:0] wq0[$];
  logic [63:0] wq1[$];
  logic        prev_we0 = 1'b0;
  logic        prev_we1 = 1'b0;

  always @(negedge clk) begin
    if (we0) begin
      wq0.push_back({waddr0, wdata0});
      chk("we0_ready_low", 32'(rdy0), 32'd0);
      chk("we0_not_back_to_back", 32'(prev_we0), 32'd0);
      chk("waddr0_aligned", 32'(waddr0[1:0]), 32'd0);
    end
    if (we1) begin
      wq1.push_back({waddr1, wdata1});
      chk("we1_ready_low", 32'(rdy1), 32'd0);
      chk("we1_not_back_to_back", 32'(prev_we1), 32'd0);
    end
    prev_we0 = we0;
    prev_we1 = we1;
  end

  // Reference model: derived from the packing rule, not from the RTL.
  logic [7:0]  img[$];
  logic [63:0] exp_q[$];
  int          exp_cnt;
  bit          exp_done;
  bit          exp_ovf;

  task automatic build_expected(input int cap);
    int n, nwords, nw;
    logic [31:0] data;
    exp_q.delete();
    n      = img.size();
    nwords = (n + 3) / 4;
    nw     = (nwords > cap) ? cap : nwords;
    for (int w = 0; w < nw; w++) begin
      data = 32'd0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) data = data | (32'(img[4 * w + k]) << (8 * k));
      exp_q.push_back({32'(4 * w), data});
    end
    exp_ovf  = (nwords > cap);
    exp_done = !exp_ovf;
    exp_cnt  = nw;
  endtask

  task automatic clear_q();
    wq0.delete();
    wq1.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents img[] byte by byte; called and returns on a falling edge.
  task automatic send_img(input bit sel, input int gap_max, input bit set_last, output int n_acc);
    bit acc;
    int gaps;
    n_acc = 0;
    for (int i = 0; i < img.size(); i++) begin
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (gaps > 0) begin
        bvalid = 1'b0;
        repeat (gaps) @(negedge clk);
      end
      bvalid = 1'b1;
      bval   = img[i];
      blast  = set_last && (i == img.size() - 1);
      acc    = 1'b0;
      for (int b = 0; b < 50 && !acc; b++) begin
        if (sel && ovf1) break;
        acc = sel ? rdy1 : rdy0;
        @(negedge clk);
      end
      if (!acc) begin
        if (!(sel && ovf1)) chk("byte_accept_timeout", 32'd0, 32'd1);
        break;
      end
      n_acc++;
    end
    bvalid = 1'b0;
    blast  = 1'b0;
  endtask

  task automatic wait_end(input bit sel);
    for (int c = 0; c < 20; c++) begin
      if (sel ? (done1 | ovf1) : (done0 | ovf0)) break;
      @(negedge clk);
    end
  endtask

  task automatic check_session(input string tag, input bit sel);
    logic [63:0] got[$];
    got = sel ? wq1 : wq0;
    chk({tag, "_nwrites"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_waddr%0d", tag, i), got[i][63:32], exp_q[i][63:32]);
      chk($sformatf("%s_wdata%0d", tag, i), got[i][31:0],  exp_q[i][31:0]);
    end
    chk({tag, "_count"}, sel ? 32'(cnt1) : 32'(cnt0), 32'(exp_cnt));
    chk({tag, "_done"},  sel ? 32'(done1) : 32'(done0), 32'(exp_done));
    chk({tag, "_ovf"},   sel ? 32'(ovf1) : 32'(ovf0), 32'(exp_ovf));
    chk({tag, "_busy"},  sel ? 32'(busy1) : 32'(busy0), 32'd0);
  endtask

  typedef struct {
    int               n;
    logic [11:0][7:0] b;
    bit               sel;
    int               nw;
    logic [2:0][31:0] ea;
    logic [2:0][31:0] ed;
    int               cnt;
    bit               done;
    bit               ovf;
  } vec_t;

  localparam int NV = 6;
  vec_t vt[NV];

  logic [7:0]  bb[6];
  bit          r[6];
  bit          w[6];
  logic [31:0] d[6];
  int          nacc;
  int          k;
  int          len;
  logic [63:0] got[$];

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1; start = 1'b0; bvalid = 1'b0; bval = 8'h00; blast = 1'b0;

    // Table: {image, target, expected writes, count, done, overflow}
    vt[0] = '{8, 96'h00000000_00100093_00000013, 1'b0, 2,
              {32'h8, 32'h4, 32'h0}, {32'h0, 32'h00100093, 32'h00000013}, 2, 1'b1, 1'b0};
    vt[1] = '{2, 96'h0000BBAA, 1'b0, 1,
              {32'h8, 32'h4, 32'h0}, {32'h0, 32'h0, 32'h0000BBAA}, 1, 1'b1, 1'b0};
    vt[2] = '{12, 96'h0C0B0A09_08070605_04030201, 1'b1, 2,
              {32'h8, 32'h4, 32'h0}, {32'h0, 32'h08070605, 32'h04030201}, 2, 1'b0, 1'b1};
    vt[3] = '{5, 96'h00000055_44332211, 1'b0, 2,
              {32'h8, 32'h4, 32'h0}, {32'h0, 32'h00000055, 32'h44332211}, 2, 1'b1, 1'b0};
    vt[4] = '{1, 96'h7F, 1'b0, 1,
              {32'h8, 32'h4, 32'h0}, {32'h0, 32'h0, 32'h0000007F}, 1, 1'b1, 1'b0};
    vt[5] = '{12, 96'hDEADBEEF_CAFEF00D_12345678, 1'b0, 3,
              {32'h8, 32'h4, 32'h0}, {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678}, 3, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_we", 32'(we0), 32'd0);
    chk("rst_waddr", waddr0, 32'd0);
    chk("rst_wdata", wdata0, 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven sessions; each restarts from DONE or ERROR.
    for (int t = 0; t < NV; t++) begin
      img.delete();
      for (int i = 0; i < vt[t].n; i++) img.push_back(vt[t].b[i]);
      clear_q();
      pulse_start();
      send_img(vt[t].sel, 0, 1'b1, nacc);
      wait_end(vt[t].sel);
      got = vt[t].sel ? wq1 : wq0;
      chk($sformatf("vec%0d_nwrites", t), 32'(got.size()), 32'(vt[t].nw));
      for (int i = 0; i < vt[t].nw && i < got.size(); i++) begin
        chk($sformatf("vec%0d_waddr%0d", t, i), got[i][63:32], vt[t].ea[i]);
        chk($sformatf("vec%0d_wdata%0d", t, i), got[i][31:0], vt[t].ed[i]);
      end
      chk($sformatf("vec%0d_count", t), vt[t].sel ? 32'(cnt1) : 32'(cnt0), 32'(vt[t].cnt));
      chk($sformatf("vec%0d_done", t), vt[t].sel ? 32'(done1) : 32'(done0), 32'(vt[t].done));
      chk($sformatf("vec%0d_ovf", t), vt[t].sel ? 32'(ovf1) : 32'(ovf0), 32'(vt[t].ovf));
    end

    // Backpressure: valid held high across a word boundary.
    bb[0] = 8'hA1; bb[1] = 8'hB2; bb[2] = 8'hC3; bb[3] = 8'hD4; bb[4] = 8'hE5; bb[5] = 8'h00;
    clear_q();
    pulse_start();
    k = 0; bvalid = 1'b1; bval = bb[0]; blast = 1'b0;
    for (int c = 0; c < 6; c++) begin
      r[c] = rdy0; w[c] = we0; d[c] = wdata0;
      @(negedge clk);
      if (r[c] && k < 5) begin
        k++;
        bval  = bb[k];
        blast = (k == 4);
      end
    end
    bvalid = 1'b0; blast = 1'b0;
    chk("bp_ready_bytes0_3", {28'd0, r[3], r[2], r[1], r[0]}, 32'hF);
    chk("bp_we_before", 32'(w[3]), 32'd0);
    chk("bp_we_after_byte4", 32'(w[4]), 32'd1);
    chk("bp_ready_during_write", 32'(r[4]), 32'd0);
    chk("bp_wdata", d[4], 32'hD4C3B2A1);
    chk("bp_we_next", 32'(w[5]), 32'd0);
    chk("bp_ready_next", 32'(r[5]), 32'd1);
    wait_end(1'b0);
    img.delete();
    img.push_back(8'hA1); img.push_back(8'hB2); img.push_back(8'hC3);
    img.push_back(8'hD4); img.push_back(8'hE5);
    build_expected(1024);
    check_session("bp", 1'b0);

    // Reset mid-word discards the partial word.
    clear_q();
    pulse_start();
    img.delete(); img.push_back(8'h11); img.push_back(8'h22);
    send_img(1'b0, 0, 1'b0, nacc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_nwrites", 32'(wq0.size()), 32'd0);
    chk("mid_rst_we", 32'(we0), 32'd0);
    chk("mid_rst_waddr", waddr0, 32'd0);
    chk("mid_rst_wdata", wdata0, 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_ready", 32'(rdy0), 32'd0);
    chk("mid_rst_count", 32'(cnt0), 32'd0);
    @(negedge clk);
    // start together with valid in IDLE: byte must not be taken that cycle.
    start = 1'b1; bvalid = 1'b1; bval = 8'h5A;
    chk("idle_start_ready", 32'(rdy0), 32'd0);
    @(negedge clk);
    start = 1'b0;
    img.delete();
    img.push_back(8'h5A); img.push_back(8'h01); img.push_back(8'h02); img.push_back(8'h03);
    send_img(1'b0, 0, 1'b0, nacc);
    repeat (2) @(negedge clk);
    chk("post_rst_nwrites", 32'(wq0.size()), 32'd1);
    if (wq0.size() > 0) begin
      chk("post_rst_waddr", wq0[0][63:32], 32'h0);
      chk("post_rst_wdata", wq0[0][31:0], 32'h0302015A);
    end
    chk("post_rst_count", 32'(cnt0), 32'd1);

    // start during COLLECT is ignored.
    pulse_start();
    chk("collect_start_busy", 32'(busy0), 32'd1);
    chk("collect_start_count", 32'(cnt0), 32'd1);
    img.delete(); img.push_back(8'hC3); img.push_back(8'h3C);
    send_img(1'b0, 1, 1'b1, nacc);
    wait_end(1'b0);
    chk("collect_start_nwrites", 32'(wq0.size()), 32'd2);
    if (wq0.size() > 1) begin
      chk("collect_start_waddr", wq0[1][63:32], 32'h4);
      chk("collect_start_wdata", wq0[1][31:0], 32'h00003CC3);
    end
    chk("collect_start_done", 32'(done0), 32'd1);
    chk("collect_start_cnt2", 32'(cnt0), 32'd2);

    // start in DONE opens a fresh session.
    clear_q();
    pulse_start();
    chk("restart_done", 32'(done0), 32'd0);
    chk("restart_count", 32'(cnt0), 32'd0);
    chk("restart_busy", 32'(busy0), 32'd1);
    img.delete(); img.push_back(8'h99);
    send_img(1'b0, 2, 1'b1, nacc);
    wait_end(1'b0);
    build_expected(1024);
    check_session("restart", 1'b0);

    // Randomized images against the reference model.
    for (int s = 0; s < 25; s++) begin
      len = int'($urandom_range(40, 1));
      img.delete();
      for (int i = 0; i < len; i++) img.push_back(8'($urandom));
      build_expected(1024);
      clear_q();
      pulse_start();
      send_img(1'b0, 2, 1'b1, nacc);
      wait_end(1'b0);
      check_session($sformatf("rnd%0d", s), 1'b0);
    end
    for (int s = 0; s < 12; s++) begin
      len = int'($urandom_range(14, 1));
      img.delete();
      for (int i = 0; i < len; i++) img.push_back(8'($urandom));
      build_expected(2);
      clear_q();
      pulse_start();
      send_img(1'b1, 1, 1'b1, nacc);
      wait_end(1'b1);
      check_session($sformatf("rndovf%0d", s), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
